hack_data_memory: RTL and testbench

Data-memory responder for the Hack CPU's memory port: decodes the CPU's `addressM`/`outM`/`writeM`, returns `inM`, and implements the standard Hack map (RAM, screen, keyboard). Screen writes are mirrored into a local screen buffer and forwarded to the display through a small FIFO with valid/ready handshake. Key codes from the keyboard front-end are latched into the keyboard register. Sits beside the CPU in the top-level computer, opposite the CPU's data-memory interface.

---
 rtl/hack_pkg.sv | 37 +++
 rtl/hack_fifo.sv | 58 +++++
 rtl/hack_data_memory.sv | 99 +++++++++
 tb/tb_hack_data_memory.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/hack_pkg.sv
// Shared definitions for the Hack data-memory responder.
// Address map constants, word widths and the screen-update entry layout.
package hack_pkg;

    localparam int WORD_W = 16;
    localparam int ADDR_W = 15;
    localparam int SCR_W  = 13;

    localparam logic [ADDR_W-1:0] RAM_BASE = 15'h0000;
    localparam logic [ADDR_W-1:0] SCR_BASE = 15'h4000;
    localparam logic [ADDR_W-1:0] KBD_ADDR = 15'h6000;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_SCR,
        REGION_KBD,
        REGION_NONE
    } region_t;

    typedef struct packed {
        logic [SCR_W-1:0]  offset;
        logic [WORD_W-1:0] data;
    } scrEntry_t;

    function automatic region_t decodeRegion(input logic [ADDR_W-1:0] addr);
        region_t r;
        r = REGION_NONE;
        unique case (1'b1)
            !addr[14]:              r = REGION_RAM;
            addr[14] && !addr[13]:  r = REGION_SCR;
            addr == KBD_ADDR:       r = REGION_KBD;
            default:                r = REGION_NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/hack_fifo.sv
// Small circular FIFO with valid/ready pop and full-gated push.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module hack_fifo #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             pushValid,
    input  logic [WIDTH-1:0] pushData,
    output logic             full,
    output logic             popValid,
    input  logic             popReady,
    output logic [WIDTH-1:0] popData
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rdPtr;
    logic [PW-1:0]    wrPtr;
    logic [PW:0]      occ;
    logic             push;
    logic             pop;

    assign full     = (occ == (PW+1)'(DEPTH));
    assign popValid = (occ != '0);
    assign popData  = mem[rdPtr];
    assign pop      = popValid && popReady;
    assign push     = pushValid && (!full || pop);

    always_ff @(posedge clock) begin
        if (reset && push) begin
            mem[wrPtr] <= pushData;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            rdPtr <= '0;
            wrPtr <= '0;
            occ   <= '0;
        end else begin
            if (push) begin
                wrPtr <= wrPtr + 1'b1;
            end
            if (pop) begin
                rdPtr <= rdPtr + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   occ <= occ + 1'b1;
                2'b01:   occ <= occ - 1'b1;
                default: occ <= occ;
            endcase
        end
    end

endmodule

// File: rtl/hack_data_memory.sv
// Hack data-memory responder: RAM, screen buffer and keyboard register,
// with screen writes forwarded to the display through a small FIFO.
module hack_data_memory
    import hack_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] addressM,
    input  logic [WORD_W-1:0] outM,
    input  logic              writeM,
    output logic [WORD_W-1:0] inM,
    input  logic              kbd_valid,
    input  logic [WORD_W-1:0] kbd_code,
    output logic              scr_valid,
    input  logic              scr_ready,
    output logic [SCR_W-1:0]  scr_addr,
    output logic [WORD_W-1:0] scr_data,
    output logic              scr_overflow
);

    logic [WORD_W-1:0] ram    [16384];
    logic [WORD_W-1:0] scrBuf [8192];
    logic [WORD_W-1:0] kbdReg;
    logic              overflow;

    region_t   region;
    logic      ramWe;
    logic      scrWe;
    logic      fifoFull;
    logic      scrPop;
    scrEntry_t pushEntry;
    scrEntry_t headEntry;

    assign region    = decodeRegion(addressM);
    assign ramWe     = reset && writeM && (region == REGION_RAM);
    assign scrWe     = reset && writeM && (region == REGION_SCR);
    assign scrPop    = scr_valid && scr_ready;
    assign pushEntry = '{offset: addressM[SCR_W-1:0], data: outM};

    always_ff @(posedge clock) begin
        if (ramWe) begin
            ram[addressM[13:0]] <= outM;
        end
    end

    always_ff @(posedge clock) begin
        if (scrWe) begin
            scrBuf[addressM[SCR_W-1:0]] <= outM;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            kbdReg <= '0;
        end else if (kbd_valid) begin
            kbdReg <= kbd_code;
        end
    end

    // Sticky until reset: a screen update was lost to a full FIFO.
    always_ff @(posedge clock) begin
        if (!reset) begin
            overflow <= 1'b0;
        end else if (scrWe && fifoFull && !scrPop) begin
            overflow <= 1'b1;
        end
    end

    always_comb begin
        inM = '0;
        unique case (region)
            REGION_RAM: inM = ram[addressM[13:0]];
            REGION_SCR: inM = scrBuf[addressM[SCR_W-1:0]];
            REGION_KBD: inM = kbdReg;
            default:    inM = '0;
        endcase
    end

    hack_fifo #(
        .WIDTH($bits(scrEntry_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .pushValid(scrWe),
        .pushData (pushEntry),
        .full     (fifoFull),
        .popValid (scr_valid),
        .popReady (scr_ready),
        .popData  (headEntry)
    );

    assign scr_addr     = headEntry.offset;
    assign scr_data     = headEntry.data;
    assign scr_overflow = overflow;

endmodule

// File: tb/tb_hack_data_memory.sv
// Directed bench for hack_data_memory: vector table for the address map,
// hand sequences for FIFO, overflow, keyboard and reset behaviour.
module tb_hack_data_memory;

    logic        clock;
    logic        reset;
    logic [14:0] addressM;
    logic [15:0] outM;
    logic        writeM;
    logic [15:0] inM;
    logic        kbd_valid;
    logic [15:0] kbd_code;
    logic        scr_valid;
    logic        scr_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        scr_overflow;

    int nAssert = 0;
    int nFail   = 0;

    typedef struct {
        logic        wr;
        logic [14:0] wAddr;
        logic [15:0] wData;
        logic [14:0] rAddr;
        logic [15:0] expRd;
    } vec_t;

    vec_t vecs[$];

    hack_data_memory #(.FIFO_DEPTH(4)) dut (
        .clock       (clock),
        .reset       (reset),
        .addressM    (addressM),
        .outM        (outM),
        .writeM      (writeM),
        .inM         (inM),
        .kbd_valid   (kbd_valid),
        .kbd_code    (kbd_code),
        .scr_valid   (scr_valid),
        .scr_ready   (scr_ready),
        .scr_addr    (scr_addr),
        .scr_data    (scr_data),
        .scr_overflow(scr_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic readCheck(input string name, input logic [14:0] a,
                             input logic [15:0] exp);
        addressM = a;
        #1;
        check(name, {16'h0, inM}, {16'h0, exp});
    endtask

    task automatic scrWrite(input logic [14:0] a, input logic [15:0] d);
        writeM   = 1'b1;
        addressM = a;
        outM     = d;
        tick();
        writeM = 1'b0;
    endtask

    function automatic vec_t mk(input logic w, input logic [14:0] wa,
                                input logic [15:0] wd, input logic [14:0] ra,
                                input logic [15:0] e);
        vec_t v;
        v.wr = w; v.wAddr = wa; v.wData = wd; v.rAddr = ra; v.expRd = e;
        return v;
    endfunction

    initial begin
        vecs.push_back(mk(1, 15'h0011, 16'h5555, 15'h0011, 16'h5555));
        vecs.push_back(mk(1, 15'h0010, 16'h1234, 15'h0010, 16'h1234));
        vecs.push_back(mk(0, 15'h0000, 16'h0000, 15'h0011, 16'h5555));
        vecs.push_back(mk(1, 15'h0000, 16'h0001, 15'h0000, 16'h0001));
        vecs.push_back(mk(1, 15'h3FFF, 16'hBEEF, 15'h3FFF, 16'hBEEF));
        vecs.push_back(mk(1, 15'h0005, 16'h7777, 15'h0005, 16'h7777));
        vecs.push_back(mk(1, 15'h4005, 16'hFFFF, 15'h0005, 16'h7777));
        vecs.push_back(mk(0, 15'h0000, 16'h0000, 15'h4005, 16'hFFFF));
        vecs.push_back(mk(1, 15'h4000, 16'h1357, 15'h4000, 16'h1357));
        vecs.push_back(mk(1, 15'h5FFF, 16'h0F0F, 15'h5FFF, 16'h0F0F));
        vecs.push_back(mk(1, 15'h1FFF, 16'hABCD, 15'h5FFF, 16'h0F0F));
        vecs.push_back(mk(0, 15'h0000, 16'h0000, 15'h1FFF, 16'hABCD));
        vecs.push_back(mk(1, 15'h2010, 16'h3333, 15'h2010, 16'h3333));
        vecs.push_back(mk(1, 15'h6010, 16'h2222, 15'h2010, 16'h3333));
        vecs.push_back(mk(0, 15'h0000, 16'h0000, 15'h6010, 16'h0000));
        vecs.push_back(mk(1, 15'h6000, 16'h9999, 15'h6000, 16'h0000));
        vecs.push_back(mk(1, 15'h6001, 16'h1111, 15'h6001, 16'h0000));
        vecs.push_back(mk(1, 15'h7FFF, 16'h4444, 15'h7FFF, 16'h0000));

        reset     = 1'b0;
        addressM  = '0;
        outM      = '0;
        writeM    = 1'b0;
        kbd_valid = 1'b0;
        kbd_code  = '0;
        scr_ready = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        check("reset scr_valid", {31'h0, scr_valid}, 32'h0);
        check("reset scr_overflow", {31'h0, scr_overflow}, 32'h0);
        readCheck("reset kbd", 15'h6000, 16'h0000);

        foreach (vecs[i]) begin
            writeM   = vecs[i].wr;
            addressM = vecs[i].wAddr;
            outM     = vecs[i].wData;
            tick();
            writeM = 1'b0;
            readCheck($sformatf("vec%0d", i), vecs[i].rAddr, vecs[i].expRd);
        end
        tick();
        check("table no overflow", {31'h0, scr_overflow}, 32'h0);
        check("table drained", {31'h0, scr_valid}, 32'h0);

        // Single screen write accepted by a ready display.
        scr_ready = 1'b1;
        scrWrite(15'h4005, 16'hFFFF);
        check("scr valid", {31'h0, scr_valid}, 32'h1);
        check("scr addr", {19'h0, scr_addr}, 32'h5);
        check("scr data", {16'h0, scr_data}, 32'hFFFF);
        readCheck("scr readback", 15'h4005, 16'hFFFF);
        tick();
        check("scr popped", {31'h0, scr_valid}, 32'h0);

        // Five writes into a stalled depth-4 FIFO.
        scr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            scrWrite(15'h4100 + 15'(i), 16'hA000 + 16'(i));
            if (i == 0) begin
                check("ovf head valid", {31'h0, scr_valid}, 32'h1);
                check("ovf head addr", {19'h0, scr_addr}, 32'h100);
            end
            if (i < 4) begin
                check($sformatf("ovf clear %0d", i),
                      {31'h0, scr_overflow}, 32'h0);
            end
        end
        check("ovf set", {31'h0, scr_overflow}, 32'h1);
        check("ovf head held addr", {19'h0, scr_addr}, 32'h100);
        check("ovf head held data", {16'h0, scr_data}, 32'hA000);
        readCheck("ovf buffer updated", 15'h4104, 16'hA004);
        scr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain%0d valid", i), {31'h0, scr_valid}, 32'h1);
            check($sformatf("drain%0d addr", i), {19'h0, scr_addr},
                  32'h100 + 32'(i));
            check($sformatf("drain%0d data", i), {16'h0, scr_data},
                  32'hA000 + 32'(i));
            tick();
        end
        check("drain empty", {31'h0, scr_valid}, 32'h0);
        check("ovf sticky", {31'h0, scr_overflow}, 32'h1);

        // Full FIFO with a push and pop in the same cycle.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        check("reset clears ovf", {31'h0, scr_overflow}, 32'h0);
        scr_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            scrWrite(15'h4200 + 15'(i), 16'hC000 + 16'(i));
        end
        check("full no ovf", {31'h0, scr_overflow}, 32'h0);
        scr_ready = 1'b1;
        scrWrite(15'h4210, 16'hC0FF);
        scr_ready = 1'b0;
        check("pushpop no ovf", {31'h0, scr_overflow}, 32'h0);
        check("pushpop head", {19'h0, scr_addr}, 32'h201);
        scr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            logic [12:0] ea;
            logic [15:0] ed;
            ea = (i < 3) ? 13'h201 + 13'(i) : 13'h210;
            ed = (i < 3) ? 16'hC001 + 16'(i) : 16'hC0FF;
            check($sformatf("pp%0d valid", i), {31'h0, scr_valid}, 32'h1);
            check($sformatf("pp%0d addr", i), {19'h0, scr_addr}, {19'h0, ea});
            check($sformatf("pp%0d data", i), {16'h0, scr_data}, {16'h0, ed});
            tick();
        end
        check("pp empty", {31'h0, scr_valid}, 32'h0);

        // Keyboard register.
        kbd_valid = 1'b1;
        kbd_code  = 16'h0041;
        tick();
        kbd_valid = 1'b0;
        kbd_code  = 16'h0042;
        readCheck("kbd load", 15'h6000, 16'h0041);
        writeM = 1'b1;
        outM   = 16'h9999;
        tick();
        writeM = 1'b0;
        readCheck("kbd cpu write ignored", 15'h6000, 16'h0041);
        tick();
        readCheck("kbd hold", 15'h6000, 16'h0041);
        readCheck("unmapped 6001", 15'h6001, 16'h0000);

        // Reset with entries queued; inputs in the reset cycle are ignored.
        scr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            scrWrite(15'h4300 + 15'(i), 16'hD000 + 16'(i));
        end
        check("pre-reset valid", {31'h0, scr_valid}, 32'h1);
        reset     = 1'b0;
        kbd_valid = 1'b1;
        kbd_code  = 16'h5555;
        writeM    = 1'b1;
        addressM  = 15'h0010;
        outM      = 16'hDEAD;
        tick();
        reset     = 1'b1;
        kbd_valid = 1'b0;
        writeM    = 1'b0;
        check("rst valid", {31'h0, scr_valid}, 32'h0);
        check("rst ovf", {31'h0, scr_overflow}, 32'h0);
        readCheck("rst kbd", 15'h6000, 16'h0000);
        readCheck("rst ram kept", 15'h0010, 16'h1234);
        scr_ready = 1'b1;
        tick();
        check("rst discarded", {31'h0, scr_valid}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAssert, nFail);
        $finish;
    end

endmodule
